// File: rtl/csr_regs.sv
// Machine-mode CSR file: trap-unit write port, CSR-instruction read/write port,
// free-running mcycle and retire-driven minstret.
module csr_regs (
  input  logic        clk,
  input  logic        rst,
  input  logic        trap_wen_i,
  input  logic        trap_mcause_we_i,
  input  logic [63:0] trap_mepc_i,
  input  logic [63:0] trap_mcause_i,
  input  logic [63:0] trap_mstatus_i,
  input  logic        csr_wen_i,
  input  logic [11:0] csr_waddr_i,
  input  logic [63:0] csr_wdata_i,
  input  logic        csr_ren_i,
  input  logic [11:0] csr_raddr_i,
  output logic [63:0] csr_rdata_o,
  input  logic        inst_retire_i,
  output logic [63:0] mtvec_o,
  output logic [63:0] mepc_o,
  output logic [63:0] mstatus_o,
  output logic        csr_illegal_o
);

  localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
  localparam logic [11:0] ADDR_MIE      = 12'h304;
  localparam logic [11:0] ADDR_MTVEC    = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
  localparam logic [11:0] ADDR_MEPC     = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
  localparam logic [11:0] ADDR_MCYCLE   = 12'hB00;
  localparam logic [11:0] ADDR_MINSTRET = 12'hB02;
  localparam logic [11:0] ADDR_MHARTID  = 12'hF14;

  logic        mst_mie_q, mst_mie_d;
  logic        mst_mpie_q, mst_mpie_d;
  logic [63:0] mie_q, mie_d;
  logic [63:2] mtvec_q, mtvec_d;
  logic [63:0] mscratch_q, mscratch_d;
  logic [63:2] mepc_q, mepc_d;
  logic [63:0] mcause_q, mcause_d;
  logic [63:0] mcycle_q, mcycle_d;
  logic [63:0] minstret_q, minstret_d;

  logic        rd_impl, wr_impl, wr_ro, wr_ok;
  logic [63:0] mstatus_rd;

  function automatic logic is_impl(input logic [11:0] addr);
    case (addr)
      ADDR_MSTATUS, ADDR_MIE, ADDR_MTVEC, ADDR_MSCRATCH, ADDR_MEPC,
      ADDR_MCAUSE, ADDR_MCYCLE, ADDR_MINSTRET, ADDR_MHARTID: is_impl = 1'b1;
      default: is_impl = 1'b0;
    endcase
  endfunction

  assign rd_impl = is_impl(csr_raddr_i);
  assign wr_impl = is_impl(csr_waddr_i);
  assign wr_ro   = (csr_waddr_i[11:10] == 2'b11);
  assign wr_ok   = csr_wen_i & wr_impl & ~wr_ro;

  assign csr_illegal_o = (csr_ren_i & ~rd_impl) | (csr_wen_i & (~wr_impl | wr_ro));

  // MPP is hard-wired to machine mode; only MIE and MPIE are stored.
  assign mstatus_rd = {51'd0, 2'b11, 3'd0, mst_mpie_q, 3'd0, mst_mie_q, 3'd0};

  assign mtvec_o   = {mtvec_q, 2'b00};
  assign mepc_o    = {mepc_q, 2'b00};
  assign mstatus_o = mstatus_rd;

  always_comb begin
    csr_rdata_o = 64'd0;
    if (csr_ren_i) begin
      case (csr_raddr_i)
        ADDR_MSTATUS:  csr_rdata_o = mstatus_rd;
        ADDR_MIE:      csr_rdata_o = mie_q;
        ADDR_MTVEC:    csr_rdata_o = {mtvec_q, 2'b00};
        ADDR_MSCRATCH: csr_rdata_o = mscratch_q;
        ADDR_MEPC:     csr_rdata_o = {mepc_q, 2'b00};
        ADDR_MCAUSE:   csr_rdata_o = mcause_q;
        ADDR_MCYCLE:   csr_rdata_o = mcycle_q;
        ADDR_MINSTRET: csr_rdata_o = minstret_q;
        default:       csr_rdata_o = 64'd0;
      endcase
    end
  end

  always_comb begin
    mst_mie_d  = mst_mie_q;
    mst_mpie_d = mst_mpie_q;
    mie_d      = mie_q;
    mtvec_d    = mtvec_q;
    mscratch_d = mscratch_q;
    mepc_d     = mepc_q;
    mcause_d   = mcause_q;
    mcycle_d   = mcycle_q + 64'd1;
    minstret_d = minstret_q + {63'd0, inst_retire_i};

    if (wr_ok) begin
      case (csr_waddr_i)
        ADDR_MSTATUS: begin
          mst_mie_d  = csr_wdata_i[3];
          mst_mpie_d = csr_wdata_i[7];
        end
        ADDR_MIE:      mie_d      = csr_wdata_i;
        ADDR_MTVEC:    mtvec_d    = csr_wdata_i[63:2];
        ADDR_MSCRATCH: mscratch_d = csr_wdata_i;
        ADDR_MEPC:     mepc_d     = csr_wdata_i[63:2];
        ADDR_MCAUSE:   mcause_d   = csr_wdata_i;
        ADDR_MCYCLE:   mcycle_d   = csr_wdata_i;
        ADDR_MINSTRET: minstret_d = csr_wdata_i;
        default: ;
      endcase
    end

    // Trap updates come last so they override a colliding CSR write.
    if (trap_wen_i) begin
      mepc_d     = trap_mepc_i[63:2];
      mst_mie_d  = trap_mstatus_i[3];
      mst_mpie_d = trap_mstatus_i[7];
      if (trap_mcause_we_i) mcause_d = trap_mcause_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_q  <= 1'b0;
      mst_mpie_q <= 1'b0;
      mie_q      <= 64'd0;
      mtvec_q    <= 62'd0;
      mscratch_q <= 64'd0;
      mepc_q     <= 62'd0;
      mcause_q   <= 64'd0;
      mcycle_q   <= 64'd0;
      minstret_q <= 64'd0;
    end else begin
      mst_mie_q  <= mst_mie_d;
      mst_mpie_q <= mst_mpie_d;
      mie_q      <= mie_d;
      mtvec_q    <= mtvec_d;
      mscratch_q <= mscratch_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
      mcycle_q   <= mcycle_d;
      minstret_q <= minstret_d;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{trap_mepc_i[1:0], trap_mstatus_i[63:8], trap_mstatus_i[6:4],
                         trap_mstatus_i[2:0]};

endmodule

// File: doc/csr_regs.md
CSR_REGS -- requirements
Module: csr_regs

Interface
REQ-001 SHALL have: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have: trap_wen_i  input  1  trap-unit write strobe for mepc/mstatus (mcause gated separately).
REQ-004 SHALL have: trap_mcause_we_i  input  1  trap-unit mcause write enable; ignored unless trap_wen_i=1.
REQ-005 SHALL have: trap_mepc_i, trap_mcause_i, trap_mstatus_i  input  64 each  trap-unit write data.
REQ-006 SHALL have: csr_wen_i  input  1; csr_waddr_i  input  12; csr_wdata_i  input  64  CSR-instruction write port.
REQ-007 SHALL have: csr_ren_i  input  1; csr_raddr_i  input  12; csr_rdata_o  output  64  CSR-instruction read port.
REQ-008 SHALL have: inst_retire_i  input  1  one instruction retired this cycle.
REQ-009 SHALL have: mtvec_o, mepc_o, mstatus_o  output  64 each  current register values, fed to the trap unit.
REQ-010 SHALL have: csr_illegal_o  output  1  access to unimplemented or read-only CSR.

Function
REQ-011 SHALL implement these CSRs: mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342, mcycle 0xB00, minstret 0xB02, mhartid 0xF14 (read-only, value 0).
REQ-012 csr_rdata_o SHALL be combinational from current register state (pre-edge value); a write in cycle N is visible on reads from cycle N+1; no bypass.
REQ-013 csr_rdata_o SHALL be 0 when csr_ren_i=0 or csr_raddr_i is unimplemented.
REQ-014 csr_illegal_o SHALL be combinational: (csr_ren_i & raddr unimplemented) | (csr_wen_i & (waddr unimplemented | waddr[11:10]==2'b11)).
REQ-015 An illegal write SHALL modify no state.
REQ-016 mstatus SHALL store only MIE[3] and MPIE[7]; MPP[12:11] SHALL read 2'b11; all other bits SHALL read 0 regardless of write data from either port.
REQ-017 mtvec writes SHALL force bits[1:0]=00 (direct mode only); mepc writes from either port SHALL force bits[1:0]=00.
REQ-018 mie, mscratch, mcause SHALL be full 64-bit read/write.
REQ-019 On trap_wen_i=1: mepc<=trap_mepc_i, mstatus<=trap_mstatus_i (masked per REQ-016); mcause<=trap_mcause_i only if trap_mcause_we_i=1.
REQ-020 Simultaneous trap and CSR writes to the same register: trap port SHALL win; CSR writes to other registers in that cycle SHALL still take effect.
REQ-021 mcycle SHALL increment by 1 every non-reset cycle, wrapping 0xFFFF_FFFF_FFFF_FFFF -> 0.
REQ-022 A CSR write to mcycle SHALL load csr_wdata_i exactly, suppressing that cycle's increment.
REQ-023 minstret SHALL increment by 1 on each cycle with inst_retire_i=1, wrapping as mcycle; a CSR write to minstret SHALL load csr_wdata_i and suppress that cycle's increment.
REQ-024 mtvec_o, mepc_o, mstatus_o SHALL equal the registered values (same masking as reads), updating one cycle after the write edge.
REQ-025 All CSR addresses SHALL decode on the full 12 bits; no aliasing.

Reset
REQ-026 On rst=1 at a rising edge: mstatus=0x0000_0000_0000_1800 (as read), mie=mtvec=mscratch=mepc=mcause=0, mcycle=0, minstret=0.
REQ-027 Reset SHALL take priority over all concurrent writes, increments and retires.
REQ-028 mcycle SHALL read 0 in the first cycle after reset release, and 1 in the next.
REQ-029 csr_rdata_o and csr_illegal_o SHALL remain purely combinational during reset (no registered state of their own).

Verification
REQ-030 Reset, then read 0x300 -> 0x1800; read 0xF14 -> 0; read 0xB00 in consecutive cycles -> 0,1,2.
REQ-031 CSR write 0x305 = 0x8000_0103 -> next cycle mtvec_o = 0x8000_0100; write 0x300 = 0xFFFF_FFFF_FFFF_FFFF -> mstatus reads 0x1888.
REQ-032 Same cycle: trap_wen_i=1, trap_mepc_i=0x8000_0040, trap_mcause_we_i=1, trap_mcause_i=11, plus CSR write 0x341=0x1234 and 0x340 would collide -> next cycle mepc=0x8000_0040, mcause=11.
REQ-033 Same cycle: trap_wen_i=1 with trap_mcause_we_i=0, trap_mcause_i=5 -> mcause unchanged; CSR write 0x340=0xAA concurrent -> mscratch=0xAA.
REQ-034 Write mcycle=0xFFFF_FFFF_FFFF_FFFE -> reads ...FE, ...FF, 0 on following cycles; minstret with retire pulsed 3 times over 5 cycles -> +3.
REQ-035 Write to 0xF14 or 0x7C0 -> csr_illegal_o=1 that cycle, all registers unchanged; rst asserted mid-sequence -> all values per REQ-026 next cycle.
